// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues one imem read at a time over req/ack,
// and holds each fetched word in a one-entry buffer drained by decode over valid/ready.
module if_stage #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_redirect,
  input  logic [WIDTH-1:0] i_pc_branch,
  output logic             o_imem_req,
  output logic [WIDTH-1:0] o_imem_addr,
  input  logic             i_imem_ack,
  input  logic [WIDTH-1:0] i_imem_rdata,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_instr,
  output logic [WIDTH-1:0] o_pc,
  output logic [WIDTH-1:0] o_pc_plus4
);

  localparam logic [WIDTH-1:0] PcStep = WIDTH'(4);

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDrop
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] req_addr_q, req_addr_d;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic [WIDTH-1:0] opc_q, opc_d;
  logic             valid_q, valid_d;

  logic             buf_free;
  logic [WIDTH-1:0] redirect_pc;

  assign buf_free    = !valid_q || i_ready;
  assign redirect_pc = {i_pc_branch[WIDTH-1:2], 2'b00};

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    instr_d    = instr_q;
    opc_d      = opc_q;
    valid_d    = valid_q;

    if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        // Only start a read when its result is guaranteed a free buffer slot.
        if (!i_redirect && buf_free) begin
          req_addr_d = pc_q;
          state_d    = StBusy;
        end
      end
      StBusy: begin
        if (i_imem_ack) begin
          if (!i_redirect) begin
            instr_d = i_imem_rdata;
            opc_d   = req_addr_q;
            valid_d = 1'b1;
            pc_d    = pc_q + PcStep;
          end
          state_d = StIdle;
        end else if (i_redirect) begin
          // Read cannot be withdrawn; wait out its ack and throw the data away.
          state_d = StDrop;
        end
      end
      StDrop: begin
        if (i_imem_ack) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (i_redirect) begin
      pc_d    = redirect_pc;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      req_addr_q <= '0;
      instr_q    <= '0;
      opc_q      <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      instr_q    <= instr_d;
      opc_q      <= opc_d;
      valid_q    <= valid_d;
    end
  end

  assign o_imem_req  = (state_q != StIdle);
  assign o_imem_addr = req_addr_q;
  assign o_valid     = valid_q;
  assign o_instr     = instr_q;
  assign o_pc        = opc_q;
  assign o_pc_plus4  = opc_q + PcStep;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios followed by random traffic,
// all compared against a transaction-level reference model of the fetch stage.
module tb_if_stage;

  localparam int unsigned W = 32;

  logic         i_clk       = 1'b0;
  logic         i_rst_n     = 1'b0;
  logic         i_redirect  = 1'b0;
  logic [W-1:0] i_pc_branch = '0;
  logic         i_imem_ack  = 1'b0;
  logic [W-1:0] i_imem_rdata = '0;
  logic         i_ready     = 1'b0;
  logic         o_imem_req;
  logic [W-1:0] o_imem_addr;
  logic         o_valid;
  logic [W-1:0] o_instr;
  logic [W-1:0] o_pc;
  logic [W-1:0] o_pc_plus4;

  int checks = 0;
  int errors = 0;

  // Reference model: next fetch address, one outstanding read (possibly doomed), one buffer.
  bit          m_out;
  bit          m_doomed;
  bit          m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_addr;
  logic [31:0] m_instr;
  logic [31:0] m_opc;

  logic [31:0] seen_pcs[$];

  if_stage #(
    .WIDTH   (W),
    .RESET_PC(32'h0)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_redirect  (i_redirect),
    .i_pc_branch (i_pc_branch),
    .o_imem_req  (o_imem_req),
    .o_imem_addr (o_imem_addr),
    .i_imem_ack  (i_imem_ack),
    .i_imem_rdata(i_imem_rdata),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_instr     (o_instr),
    .o_pc        (o_pc),
    .o_pc_plus4  (o_pc_plus4)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h00500093;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_out    = 1'b0;
    m_doomed = 1'b0;
    m_valid  = 1'b0;
    m_pc     = 32'h0;
    m_addr   = 32'h0;
    m_instr  = 32'h0;
    m_opc    = 32'h0;
  endtask

  task automatic model_step(input bit redir, input logic [31:0] tgt, input bit ack,
                            input bit rdy);
    bit free;
    free = !m_valid || rdy;
    if (m_valid && rdy) m_valid = 1'b0;
    if (m_out) begin
      if (ack) begin
        if (!m_doomed && !redir) begin
          m_valid = 1'b1;
          m_instr = mem(m_addr);
          m_opc   = m_addr;
          m_pc    = m_pc + 32'd4;
        end
        m_out    = 1'b0;
        m_doomed = 1'b0;
      end else if (redir) begin
        m_doomed = 1'b1;
      end
    end else if (!redir && free) begin
      m_out  = 1'b1;
      m_addr = m_pc;
    end
    if (redir) begin
      m_pc    = tgt & 32'hFFFF_FFFC;
      m_valid = 1'b0;
    end
  endtask

  task automatic cmp_model();
    chk("req", {31'd0, o_imem_req}, {31'd0, m_out});
    chk("addr", o_imem_addr, m_addr);
    chk("valid", {31'd0, o_valid}, {31'd0, m_valid});
    chk("instr", o_instr, m_instr);
    chk("pc", o_pc, m_opc);
    chk("pc_plus4", o_pc_plus4, m_opc + 32'd4);
    if (o_valid) chk("instr_matches_pc", o_instr, mem(o_pc));
  endtask

  // Drive one cycle of inputs just after an edge, advance the model, check after the next edge.
  task automatic step(input bit redir, input logic [31:0] tgt, input bit ack, input bit rdy);
    bit a;
    a = ack && o_imem_req;
    i_redirect   = redir;
    i_pc_branch  = tgt;
    i_imem_ack   = a;
    i_ready      = rdy;
    i_imem_rdata = mem(o_imem_addr);
    model_step(redir, tgt, a, rdy);
    @(posedge i_clk);
    #1;
    cmp_model();
  endtask

  initial begin
    model_reset();

    // Reset held for three edges.
    repeat (3) begin
      @(posedge i_clk);
      #1;
      cmp_model();
    end
    chk("rst_plus4", o_pc_plus4, 32'h4);
    i_rst_n = 1'b1;

    // First fetch.
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("first_req", {31'd0, o_imem_req}, 32'd1);
    chk("first_addr", o_imem_addr, 32'h0);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    chk("first_instr", o_instr, 32'h00500093);
    chk("first_valid", {31'd0, o_valid}, 32'd1);

    // Zero-wait stream.
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 32'h0, 1'b1, 1'b1);
      if (o_valid) seen_pcs.push_back(o_pc);
    end
    chk("stream_count", seen_pcs.size(), 32'd3);
    for (int i = 0; i < seen_pcs.size(); i++) chk("stream_pc", seen_pcs[i], 32'(4 * (i + 1)));

    // Backpressure with buffer full.
    repeat (5) begin
      step(1'b0, 32'h0, 1'b0, 1'b0);
      chk("bp_noreq", {31'd0, o_imem_req}, 32'd0);
      chk("bp_pc", o_pc, 32'hC);
    end
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("bp_next_addr", o_imem_addr, 32'h10);
    step(1'b0, 32'h0, 1'b1, 1'b1);

    // Redirect while the read of 0x8 waits three cycles for its ack.
    step(1'b1, 32'h8, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b1, 32'h100, 1'b0, 1'b1);
    chk("drop_addr", o_imem_addr, 32'h8);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("drop_addr2", o_imem_addr, 32'h8);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    chk("drop_novalid", {31'd0, o_valid}, 32'd0);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("tgt_addr", o_imem_addr, 32'h100);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    chk("tgt_pc", o_pc, 32'h100);

    // Misaligned target and address wrap.
    step(1'b1, 32'h103, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("align_addr", o_imem_addr, 32'h100);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    chk("wrap_pc", o_pc, 32'hFFFF_FFFC);
    chk("wrap_plus4", o_pc_plus4, 32'h0);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("wrap_addr", o_imem_addr, 32'h0);
    chk("wrap_req", {31'd0, o_imem_req}, 32'd1);

    // Asynchronous reset between edges while a read is outstanding.
    #2;
    i_imem_ack = 1'b0;
    i_rst_n    = 1'b0;
    model_reset();
    #1;
    chk("async_req", {31'd0, o_imem_req}, 32'd0);
    chk("async_valid", {31'd0, o_valid}, 32'd0);
    @(posedge i_clk);
    #1;
    cmp_model();
    i_rst_n = 1'b1;
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("restart_addr", o_imem_addr, 32'h0);
    chk("restart_req", {31'd0, o_imem_req}, 32'd1);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      bit          redir;
      logic [31:0] tgt;
      redir = ($urandom_range(9) == 0);
      tgt   = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
      step(redir, tgt, $urandom_range(2) == 0, $urandom_range(2) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the RISC-V pipeline, the consumer of the execute stage's branch target. It owns the program counter and issues one instruction-memory read at a time over a req/ack handshake. Each fetched word is held in a one-entry output buffer that the decode stage drains over a valid/ready handshake. A redirect from execute (taken branch or jump) flushes the buffer, discards any in-flight read, and restarts fetch at the target.

## Interface
- `WIDTH`, default 32: datapath and address width.
- `RESET_PC`, default 0: PC value after reset.

- `i_clk`  in  1: clock; all state updates on the rising edge.
- `i_rst_n`  in  1: reset, asynchronous, active-low.
- `i_redirect`  in  1: taken branch or jump from execute.
- `i_pc_branch`  in  WIDTH: redirect target, the execute-stage branch adder output.
- `o_imem_req`  out  1: read request to instruction memory.
- `o_imem_addr`  out  WIDTH: read address; stable while `o_imem_req` is high.
- `i_imem_ack`  in  1: read data valid; meaningful only while `o_imem_req` is high.
- `i_imem_rdata`  in  WIDTH: instruction word, sampled when `i_imem_ack` is high.
- `o_valid`  out  1: output buffer holds an instruction.
- `i_ready`  in  1: decode accepts the instruction; transfer happens when `o_valid` and `i_ready` are both high.
- `o_instr`  out  WIDTH: buffered instruction.
- `o_pc`  out  WIDTH: address of `o_instr`.
- `o_pc_plus4`  out  WIDTH: `o_pc` + 4, modulo 2^WIDTH, for link registers.

## Operation
- Registers:
  - `pc`: next fetch address.
  - `req_addr`: drives `o_imem_addr`.
  - FSM state: IDLE, BUSY, DROP.
  - Output buffer: `o_valid`, `o_instr`, `o_pc`.
- `o_imem_req` is 1 exactly in BUSY and DROP. It comes from the state register, so it is never combinational from inputs.
- "Buffer free next cycle" means `!o_valid || i_ready`.

- IDLE, no redirect, buffer free next cycle: `req_addr <= pc`, go to BUSY.
- IDLE, otherwise: stay in IDLE.
- BUSY with `i_imem_ack`:
  - Load `o_instr <= i_imem_rdata`, `o_pc <= req_addr`, `o_valid <= 1`.
  - `pc <= pc + 4`, wrapping modulo 2^WIDTH.
  - Go to IDLE.
- BUSY without ack: hold state.
- DROP with ack: discard the data, go to IDLE.
- DROP without ack: hold state.
- The start rule guarantees the buffer is empty whenever an ack is captured; no overflow path exists.
- Transfer (`o_valid && i_ready`, no load the same cycle): `o_valid <= 0`.

- Redirect has highest priority in every state:
  - `pc <= {i_pc_branch[WIDTH-1:2], 2'b00}`; misaligned targets are truncated.
  - `o_valid <= 0`, even if `i_ready` is high the same cycle; that transfer is void.
  - IDLE goes to IDLE; no request is started in the redirect cycle.
  - BUSY without ack goes to DROP. The request stays asserted with the old `req_addr` until it is acked.
  - BUSY or DROP with ack: the data is discarded and the FSM goes to IDLE.
  - DROP without ack stays in DROP, with only `pc` updated.
- Wrong-path data never appears on `o_valid`.

## Timing
- Reset values: state IDLE, `pc` = RESET_PC, `req_addr` = 0, `o_imem_req` = 0, `o_imem_addr` = 0, `o_valid` = 0, `o_instr` = 0, `o_pc` = 0, `o_pc_plus4` = 4.
- Reset takes effect immediately on assertion, including mid-request. The in-flight read is abandoned and the memory must tolerate the request dropping.
- First request: `o_imem_req` rises on the first rising edge after `i_rst_n` deasserts, with `o_imem_addr` = RESET_PC.
- Latency with a zero-wait memory (ack in the same cycle as req): `o_valid` is high 1 cycle after the req cycle.
- Throughput is 1 instruction per 2 cycles at best (IDLE/BUSY alternate). With N wait cycles, a fetch takes N+2 cycles.
- While `o_valid` && !`i_ready` && no redirect:
  - `o_instr` and `o_pc` are held stable.
  - No new request starts.
- After a redirect from IDLE or BUSY-with-ack, the request to the target rises 2 edges after the redirect edge.
- From DROP, the request to the target rises 2 edges after the old ack.

## Test plan
- Reset and first fetch: hold `i_rst_n` low for 3 cycles, then release.
  - During reset, every output is at its reset value.
  - Edge 1 after release: req=1, addr=0x0.
  - Ack with 0x00500093: edge 2 gives `o_valid`=1, `o_instr`=0x00500093, `o_pc`=0, `o_pc_plus4`=4.
- Zero-wait stream with `i_ready`=1: `o_pc` sequence 0x0, 0x4, 0x8, 0xC, with `o_valid` high every other cycle.
- Backpressure: `i_ready`=0 for 5 cycles with the buffer full.
  - `o_instr`/`o_pc` unchanged and `o_imem_req` stays 0.
  - `i_ready`=1 gives one transfer, then a request to the next address.
- Redirect while a read of 0x8 is outstanding with 3-cycle ack latency; `i_pc_branch`=0x100 pulsed for 1 cycle.
  - `o_imem_addr` stays 0x8 until the ack; the 0x8 data is never valid.
  - The next request goes to 0x100, and `o_pc`=0x100.
- Alignment and wrap:
  - Redirect to 0x103 fetches 0x100.
  - Redirect to 0xFFFFFFFC: after that fetch, the next `o_imem_addr` is 0x0 and `o_pc_plus4` shows 0x0.
- Async reset mid-request: drop `i_rst_n` between clock edges while in BUSY.
  - `o_imem_req` and `o_valid` go to 0 immediately, with no clock edge needed.
  - After release, fetch restarts at RESET_PC.
